pe_vec_mac: RTL and testbench

Parametrised vector processing element, successor to the fixed 16-lane PE. It applies one of four lane operations (MUL, ADD, MAC, PASS) to LANES operand pairs per beat, with optional dequantisation shift and a per-lane accumulator. Results can be fed back as the next beat's operand and then either emitted per lane or reduced through a pipelined adder tree. The block sits between the operand buffers and the PE output collector, and uses valid/ready on both sides in place of level-controlled select lines.

---
 rtl/pe_vec_mac_if.sv | 30 +++
 rtl/pe_vec_mac.sv | 97 +++++++++
 tb/tb_pe_vec_mac.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pe_vec_mac_if.sv
// pe_vec_mac_if: operand/result valid-ready bus of the vector PE
// Parameters: LANES (lane count), DW (lane width).
// master: drives in_valid, in_a, in_b, op, fb_sel, deq, clr_acc, reduce, out_ready.
// slave:  drives in_ready, out_valid, out_vec, out_sum.
interface pe_vec_mac_if #(
  parameter int LANES = 16,
  parameter int DW    = 32
) ();
  logic                in_valid;
  logic                in_ready;
  logic [LANES*DW-1:0] in_a;
  logic [LANES*DW-1:0] in_b;
  logic [1:0]          op;
  logic [1:0]          fb_sel;
  logic                deq;
  logic                clr_acc;
  logic                reduce;
  logic                out_valid;
  logic                out_ready;
  logic [LANES*DW-1:0] out_vec;
  logic [DW-1:0]       out_sum;
  modport master (
    output in_valid, in_a, in_b, op, fb_sel, deq, clr_acc, reduce, out_ready,
    input  in_ready, out_valid, out_vec, out_sum
  );
  modport slave (
    input  in_valid, in_a, in_b, op, fb_sel, deq, clr_acc, reduce, out_ready,
    output in_ready, out_valid, out_vec, out_sum
  );
endinterface

// File: rtl/pe_vec_mac.sv
// pe_vec_mac: LANES-wide MUL/ADD/MAC/PASS processing element with feedback and pipelined reduction
// Ports: clk (rising edge), rst (asynchronous, active-low), bus (pe_vec_mac_if.slave).
// Latency 1+log2(LANES) from accept to out_valid; whole pipeline holds while out_valid && !out_ready.
// Optional PE_SATURATE_EN: MUL/ADD/MAC lane results saturate instead of wrapping.
module pe_vec_mac #(
  parameter int LANES = 16,
  parameter int DW    = 32,
  parameter int SHIFT = 16
) (
  input  logic         clk,
  input  logic         rst,
  pe_vec_mac_if.slave  bus
);
  localparam int L = $clog2(LANES);
`ifdef PE_SATURATE_EN
  localparam logic signed [2*DW:0] sat_max = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW:0] sat_min = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};
  function automatic logic [DW-1:0] fit(input logic signed [2*DW:0] x);
    return x > sat_max ? sat_max[DW-1:0] : x < sat_min ? sat_min[DW-1:0] : x[DW-1:0];
  endfunction
`else
  function automatic logic [DW-1:0] fit(input logic signed [2*DW:0] x);
    return x[DW-1:0];
  endfunction
`endif
  logic                stall, take;
  logic [1:0]          fb;
  logic [LANES*DW-1:0] acc, res_d, acc_d;
  // stage 0 of these arrays is the lane result register res
  logic [LANES*DW-1:0] vec [0:L];
  logic                vld [0:L];
  logic                red [0:L];
  assign stall        = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall;
  assign take         = bus.in_valid && !stall;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DW-1:0]   a, b, base;
    logic signed [2*DW-1:0] p, ps;
    logic signed [2*DW:0]   mac;
    logic [DW-1:0]          mac_r, r;
    always_comb begin
      a     = fb == 2'b10 ? vec[0][i*DW +: DW] : bus.in_a[i*DW +: DW];
      b     = fb == 2'b01 ? vec[0][i*DW +: DW] : bus.in_b[i*DW +: DW];
      base  = bus.clr_acc ? '0 : acc[i*DW +: DW];
      p     = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
      ps    = bus.deq ? p >>> SHIFT : p;
      mac   = {{(DW+1){base[DW-1]}}, base} + {ps[2*DW-1], ps};
      mac_r = fit(mac);
      r     = bus.op == 2'b00 ? fit({ps[2*DW-1], ps}) :
              bus.op == 2'b01 ? fit({{(DW+1){a[DW-1]}}, a} + {{(DW+1){b[DW-1]}}, b}) :
              bus.op == 2'b10 ? mac_r : a;
    end
    assign res_d[i*DW +: DW] = r;
    assign acc_d[i*DW +: DW] = bus.op == 2'b10 ? mac_r : bus.clr_acc ? '0 : acc[i*DW +: DW];
  end
  // res, acc and the feedback mode change only on accept, so feedback survives idle cycles
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc <= '0;
      fb  <= 2'b00;
      for (int l = 0; l <= L; l++) begin
        vec[l] <= '0;
        vld[l] <= 1'b0;
        red[l] <= 1'b0;
      end
    end else if (!stall) begin
      vld[0] <= take;
      red[0] <= take && bus.reduce;
      if (take) begin
        vec[0] <= res_d;
        acc    <= acc_d;
        fb     <= bus.fb_sel == 2'b11 ? 2'b00 : bus.fb_sel;
      end
      for (int l = 1; l <= L; l++) begin
        vec[l] <= vec[l-1];
        vld[l] <= vld[l-1];
        red[l] <= red[l-1];
      end
    end
  for (genvar g = 1; g <= L; g++) begin : g_lvl
    localparam int n = LANES >> g;
    logic [2*n*DW-1:0] src;
    logic [n*DW-1:0]   s;
    if (g == 1) begin : g_first
      assign src = vec[0];
    end else begin : g_next
      assign src = g_lvl[g-1].s;
    end
    always_ff @(posedge clk or negedge rst)
      if (!rst) s <= '0;
      else if (!stall)
        for (int j = 0; j < n; j++) s[j*DW +: DW] <= src[2*j*DW +: DW] + src[(2*j+1)*DW +: DW];
  end
  assign bus.out_valid = vld[L];
  assign bus.out_vec   = vec[L];
  assign bus.out_sum   = red[L] ? g_lvl[L].s : '0;
endmodule

// File: tb/tb_pe_vec_mac.sv
// tb_pe_vec_mac: table-driven and scoreboarded bench for pe_vec_mac (LANES=16, DW=32, SHIFT=16)
module tb_pe_vec_mac;
  localparam int LANES = 16, DW = 32, N = LANES * DW;
`ifdef PE_SATURATE_EN
  localparam bit sat = 1'b1;
`else
  localparam bit sat = 1'b0;
`endif
  typedef struct {
    logic [N-1:0]  vec;
    logic [DW-1:0] sum;
  } exp_t;
  typedef struct {
    logic [1:0]    op, fb;
    logic          deq, clr, red;
    int            gap;
    logic [DW-1:0] a, b, el, es;
  } row_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  pe_vec_mac_if #(.LANES(LANES), .DW(DW)) bus ();
  pe_vec_mac #(.LANES(LANES), .DW(DW), .SHIFT(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  exp_t q[$];
  row_t tv [0:17];
  int checks = 0, errors = 0;
  int n, k, cyc, sc;
  logic was_stall, take;
  logic [N-1:0] sv, va, vb, ev;
  logic [DW-1:0] ss, es;
  function automatic logic [N-1:0] rep(input logic [DW-1:0] v);
    logic [N-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = v;
    return r;
  endfunction
  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [1:0] op, fb, input logic deq, clr, red,
                       input logic [N-1:0] a, b, input logic push,
                       input logic [N-1:0] xv, input logic [DW-1:0] xs);
    exp_t e;
    @(negedge clk);
    bus.op = op; bus.fb_sel = fb; bus.deq = deq; bus.clr_acc = clr; bus.reduce = red;
    bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
    #1 chk("in_ready", N'(bus.in_ready), N'(1'b1));
    if (push) begin
      e.vec = xv; e.sum = xs;
      q.push_back(e);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    #3 checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending beats expected 0", q.size());
    end
  endtask
  always @(negedge clk) begin
    #2;
    if (rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: got beat %h expected none", bus.out_sum);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_vec", bus.out_vec, e.vec);
        chk("out_sum", N'(bus.out_sum), N'(e.sum));
      end
    end
  end
  initial begin
    tv[0]  = '{2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 0, 32'd3, 32'd5, 32'd15, 32'd240};
    tv[1]  = '{2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 0, 32'h00030000, 32'h00020000, 32'h00060000, 32'h00600000};
    tv[2]  = '{2'd2, 2'd0, 1'b0, 1'b1, 1'b1, 0, 32'd2, 32'd2, 32'd4, 32'd64};
    tv[3]  = '{2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 0, 32'd2, 32'd2, 32'd8, 32'd128};
    tv[4]  = '{2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 0, 32'd2, 32'd2, 32'd12, 32'd0};
    tv[5]  = '{2'd1, 2'd0, 1'b0, 1'b1, 1'b1, 0, 32'd7, 32'd8, 32'd15, 32'd240};
    tv[6]  = '{2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 0, 32'd1, 32'd1, 32'd1, 32'd16};
    tv[7]  = '{2'd1, 2'd2, 1'b0, 1'b0, 1'b1, 0, 32'd1, 32'd1, 32'd2, 32'd32};
    tv[8]  = '{2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 3, 32'd99, 32'd4, 32'd6, 32'd96};
    tv[9]  = '{2'd3, 2'd1, 1'b0, 1'b0, 1'b1, 0, 32'hFFFFFFFB, 32'd9, 32'hFFFFFFFB, 32'hFFFFFFB0};
    tv[10] = '{2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 0, 32'd3, 32'd1000, 32'hFFFFFFF1, 32'hFFFFFF10};
    tv[11] = '{2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 0, 32'h7FFFFFFF, 32'd2,
               sat ? 32'h7FFFFFFF : 32'hFFFFFFFE, sat ? 32'hFFFFFFF0 : 32'hFFFFFFE0};
    tv[12] = '{2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 0, 32'h7FFFFFFF, 32'd1,
               sat ? 32'h7FFFFFFF : 32'h80000000, sat ? 32'hFFFFFFF0 : 32'h0};
    tv[13] = '{2'd1, 2'd3, 1'b0, 1'b0, 1'b1, 0, 32'd1, 32'd1, 32'd2, 32'd32};
    tv[14] = '{2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 0, 32'd10, 32'd20, 32'd30, 32'd480};
    tv[15] = '{2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 0, 32'hFFFD0000, 32'h00020000, 32'hFFFA0000, 32'hFFA00000};
    tv[16] = '{2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 0, 32'h7FFFFFFF, 32'd1,
               sat ? 32'h7FFFFFFF : 32'h80000000, sat ? 32'hFFFFFFF0 : 32'h0};
    tv[17] = '{2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 0, 32'd1, 32'd1,
               sat ? 32'h7FFFFFFF : 32'h80000001, sat ? 32'hFFFFFFF0 : 32'h10};
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.op = 2'b00; bus.fb_sel = 2'b00;
    bus.deq = 1'b0; bus.clr_acc = 1'b0; bus.reduce = 1'b0; bus.out_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_out_valid", N'(bus.out_valid), N'(1'b0));
    chk("rst_out_vec", bus.out_vec, '0);
    chk("rst_out_sum", N'(bus.out_sum), '0);
    chk("rst_in_ready", N'(bus.in_ready), N'(1'b1));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive(2'd0, 2'd0, 1'b0, 1'b0, 1'b1, rep(32'd3), rep(32'd5), 1'b1, rep(32'd15), 32'd240);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (bus.out_valid) break;
    end
    chk("latency", N'(n), N'(5));
    @(negedge clk);
    chk("valid_pulse", N'(bus.out_valid), N'(1'b0));
    for (int r = 0; r < 18; r++) begin
      repeat (tv[r].gap) @(posedge clk);
      drive(tv[r].op, tv[r].fb, tv[r].deq, tv[r].clr, tv[r].red, rep(tv[r].a), rep(tv[r].b),
            1'b1, rep(tv[r].el), tv[r].es);
    end
    es = '0;
    for (int i = 0; i < LANES; i++) begin
      va[i*DW +: DW] = DW'(i + 1);
      vb[i*DW +: DW] = DW'(i - 8);
      ev[i*DW +: DW] = DW'((i + 1) * (i - 8));
      es += DW'((i + 1) * (i - 8));
    end
    drive(2'd0, 2'd0, 1'b0, 1'b0, 1'b1, va, vb, 1'b1, ev, es);
    drain();
    k = 0; cyc = 0; sc = -1; was_stall = 1'b0;
    while (k < 10 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (was_stall) begin
        chk("stall_vec_hold", bus.out_vec, sv);
        chk("stall_sum_hold", N'(bus.out_sum), N'(ss));
      end
      if (bus.out_valid && sc < 0) sc = 4;
      bus.out_ready = !(sc > 0);
      if (sc > 0) sc--;
      bus.op = 2'd0; bus.fb_sel = 2'd0; bus.deq = 1'b0; bus.clr_acc = 1'b0; bus.reduce = 1'b1;
      bus.in_a = rep(DW'(k + 100)); bus.in_b = rep(32'd1); bus.in_valid = 1'b1;
      #1;
      chk("stall_in_ready", N'(bus.in_ready), N'(!(bus.out_valid && !bus.out_ready)));
      was_stall = bus.out_valid && !bus.out_ready;
      sv = bus.out_vec; ss = bus.out_sum;
      take = bus.in_ready;
      if (take) begin
        exp_t e;
        e.vec = rep(DW'(k + 100)); e.sum = DW'(16 * (k + 100));
        q.push_back(e);
        k++;
      end
      @(posedge clk);
    end
    chk("stall_all_sent", N'(k), N'(10));
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    drain();
    for (int i = 0; i < 5; i++)
      drive(2'd1, i == 4 ? 2'd2 : 2'd0, 1'b0, 1'b0, 1'b1, rep(DW'(i + 1)), rep(32'd1), 1'b0, '0, '0);
    chk("pre_rst_valid", N'(bus.out_valid), N'(1'b1));
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", N'(bus.out_valid), N'(1'b0));
    chk("mid_rst_out_vec", bus.out_vec, '0);
    chk("mid_rst_out_sum", N'(bus.out_sum), '0);
    chk("mid_rst_in_ready", N'(bus.in_ready), N'(1'b1));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive(2'd2, 2'd0, 1'b0, 1'b0, 1'b1, rep(32'd1), rep(32'd1), 1'b1, rep(32'd1), 32'd16);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
